// File: rtl/nonogram_solver.sv
// Nonogram line propagator: filters candidate patterns for one line at a
// time against deduced cells and commits cells all survivors agree on.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   started             start pulse (qualified by valid_op), new puzzle
//   option              stream word: line index or candidate pattern
//   num_rows, num_cols  active board size R, C (1..SIZE)
//   valid_op            option word valid this cycle
//   old_options_amnt    initial candidate count per line, sampled on start
//   put_back_to_FIFO    last accepted candidate survived, re-queue it
//   assigned, known     cell values and deduced flags, [row][col]
//   solved              every active cell is known
module nonogram_solver #(
    parameter int SIZE = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      started,
    input  logic [SIZE-1:0]           option,
    input  logic [3:0]                num_rows,
    input  logic [3:0]                num_cols,
    input  logic                      valid_op,
    input  logic [2*SIZE-1:0][6:0]    old_options_amnt,
    output logic                      put_back_to_FIFO,
    output logic [SIZE-1:0][SIZE-1:0] assigned,
    output logic [SIZE-1:0][SIZE-1:0] known,
    output logic                      solved
);

    localparam int LW = $clog2(2 * SIZE);

    typedef enum logic [1:0] {
        IDLE,
        EXPECT_INDEX,
        OPTIONS
    } state_t;

    state_t state, state_n;

    logic [2*SIZE-1:0][6:0] cnt;
    logic [LW-1:0]          lidx;
    logic                   is_row;
    logic [3:0]             pos;
    logic [6:0]             base, seen, survivors;
    logic [SIZE-1:0]        and1, and0;

    logic                   load, take_index, take_cand;
    logic [7:0]             l_ext;
    logic                   in_range, row_word;
    logic [3:0]             pos_word;
    logic [LW-1:0]          lsel;
    logic [6:0]             base_word;

    logic [SIZE-1:0]        line_known, line_val;
    logic                   conflict, consistent, last, commit;
    logic [SIZE-1:0]        and1_c, and0_c;
    logic [6:0]             surv_c;
    logic [SIZE-1:0][SIZE-1:0] set1, set0;
    logic                   all_known;

    // Cell (r,c) sits at option bit b of the current line:
    // row line r: b = C-1-c ; column line c: b = R-1-r.
    function automatic logic hit(input logic row, input logic [3:0] p,
                                 input logic [3:0] nr, input logic [3:0] nc,
                                 input int r, input int c, input int b);
        if (row)
            return (p == 4'(r)) && (nc == 4'(c + b + 1));
        return (p == 4'(c)) && (nr == 4'(r + b + 1));
    endfunction

    // Index word decode
    assign l_ext     = 8'(option);
    assign in_range  = l_ext < (8'(num_rows) + 8'(num_cols));
    assign row_word  = l_ext < 8'(num_rows);
    assign pos_word  = row_word ? l_ext[3:0] : 4'(l_ext - 8'(num_rows));
    assign lsel      = option[LW-1:0];
    // On start the counts load this same cycle, so read them at the source.
    assign base_word = started ? old_options_amnt[lsel] : cnt[lsel];

    // Gather the current line's deduced cells into option bit order
    always_comb begin
        line_known = '0;
        line_val   = '0;
        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++)
                for (int b = 0; b < SIZE; b++)
                    if (hit(is_row, pos, num_rows, num_cols, r, c, b)) begin
                        line_known[b] = line_known[b] | known[r][c];
                        line_val[b]   = line_val[b] | assigned[r][c];
                    end
    end

    assign conflict   = |(line_known & (line_val ^ option));
    assign consistent = ~conflict;
    assign and1_c     = consistent ? (and1 & option) : and1;
    assign and0_c     = consistent ? (and0 & ~option) : and0;
    assign surv_c     = survivors + 7'(consistent);
    assign last       = (seen + 7'd1) == base;
    assign commit     = take_cand & last & (surv_c != 7'd0);

    // Agreed cells scattered back onto the board, skipping known ones
    always_comb begin
        set1 = '0;
        set0 = '0;
        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++)
                for (int b = 0; b < SIZE; b++)
                    if (hit(is_row, pos, num_rows, num_cols, r, c, b)) begin
                        set1[r][c] = set1[r][c] | (and1_c[b] & ~known[r][c]);
                        set0[r][c] = set0[r][c] | (and0_c[b] & ~known[r][c]);
                    end
    end

    always_comb begin
        all_known = 1'b1;
        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++)
                if ((4'(r) < num_rows) && (4'(c) < num_cols) && !known[r][c])
                    all_known = 1'b0;
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    // FSM: next state
    always_comb begin
        state_n = state;
        if (take_index)
            state_n = (in_range && base_word != 7'd0) ? OPTIONS : EXPECT_INDEX;
        else if (take_cand && last)
            state_n = EXPECT_INDEX;
    end

    // FSM: control decode
    always_comb begin
        load       = valid_op & started;
        take_index = valid_op & (started | (state == EXPECT_INDEX));
        take_cand  = valid_op & ~started & (state == OPTIONS);
    end

    // Datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt              <= '0;
            lidx             <= '0;
            is_row           <= 1'b0;
            pos              <= '0;
            base             <= '0;
            seen             <= '0;
            survivors        <= '0;
            and1             <= '0;
            and0             <= '0;
            put_back_to_FIFO <= 1'b0;
            known            <= '0;
            assigned         <= '0;
            solved           <= 1'b0;
        end else begin
            if (load) begin
                cnt      <= old_options_amnt;
                known    <= '0;
                assigned <= '0;
            end else if (commit) begin
                known    <= known | set1 | set0;
                assigned <= assigned | set1;
            end

            if (take_index) begin
                put_back_to_FIFO <= 1'b0;
                if (in_range) begin
                    lidx      <= lsel;
                    is_row    <= row_word;
                    pos       <= pos_word;
                    base      <= base_word;
                    seen      <= '0;
                    survivors <= '0;
                    and1      <= '1;
                    and0      <= '1;
                end
            end else if (take_cand) begin
                // A sole remaining candidate is final; no need to re-queue.
                put_back_to_FIFO <= consistent && (base != 7'd1);
                seen      <= seen + 7'd1;
                survivors <= surv_c;
                and1      <= and1_c;
                and0      <= and0_c;
                if (conflict)
                    cnt[lidx] <= cnt[lidx] - 7'd1;
            end

            solved <= load ? 1'b0 : (solved | all_known);
        end
    end

endmodule

// File: tb/tb_nonogram_solver.sv
// Self-checking bench for nonogram_solver: scoreboard on put_back_to_FIFO
// plus direct board checks at line boundaries.
module tb_nonogram_solver;

    logic            clk;
    logic            rst;
    logic            started;
    logic [2:0]      option;
    logic [3:0]      num_rows;
    logic [3:0]      num_cols;
    logic            valid_op;
    logic [5:0][6:0] amnt;
    logic            put_back_to_FIFO;
    logic [2:0][2:0] assigned;
    logic [2:0][2:0] known;
    logic            solved;

    int checks   = 0;
    int failures = 0;

    logic exp_q[$];
    logic exp_e;

    nonogram_solver #(.SIZE(3)) dut (
        .clk              (clk),
        .rst              (rst),
        .started          (started),
        .option           (option),
        .num_rows         (num_rows),
        .num_cols         (num_cols),
        .valid_op         (valid_op),
        .old_options_amnt (amnt),
        .put_back_to_FIFO (put_back_to_FIFO),
        .assigned         (assigned),
        .known            (known),
        .solved           (solved)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard monitor: every accepted word has a queued put_back value
    always @(posedge clk) begin
        if (rst && valid_op) begin
            #1;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_empty got=%b", put_back_to_FIFO);
            end else begin
                exp_e = exp_q.pop_front();
                if (put_back_to_FIFO !== exp_e) begin
                    failures++;
                    $display("FAIL put_back got=%b exp=%b", put_back_to_FIFO, exp_e);
                end
            end
        end
    end

    task automatic step(input logic [2:0] w, input logic st, input logic epb);
        option   = w;
        started  = st;
        valid_op = 1'b1;
        exp_q.push_back(epb);
        @(posedge clk);
        #1;
        started = 1'b0;
    endtask

    task automatic idle();
        valid_op = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; started = 1'b0; valid_op = 1'b0; option = '0;
        num_rows = 4'd3; num_cols = 4'd3; amnt = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (put_back_to_FIFO !== 1'b0) begin
            failures++; $display("FAIL reset_pb got=%b exp=0", put_back_to_FIFO);
        end
        checks++;
        if (known !== 9'h0) begin
            failures++; $display("FAIL reset_known got=%h exp=0", known);
        end
        checks++;
        if (assigned !== 9'h0) begin
            failures++; $display("FAIL reset_assigned got=%h exp=0", assigned);
        end
        checks++;
        if (solved !== 1'b0) begin
            failures++; $display("FAIL reset_solved got=%b exp=0", solved);
        end
        rst = 1'b1;
        // IDLE ignores non-start words
        step(3'b001, 1'b0, 1'b0);
    endtask

    task automatic test_puzzle();
        num_rows = 4'd3; num_cols = 4'd3;
        amnt = {7'd3, 7'd2, 7'd1, 7'd1, 7'd3, 7'd2};
        step(3'd0, 1'b1, 1'b0);
        step(3'b110, 1'b0, 1'b1);
        step(3'b011, 1'b0, 1'b1);
        checks++;
        if (known !== 9'b000_000_010 || assigned !== 9'b000_000_010) begin
            failures++;
            $display("FAIL row0_commit got=%b/%b exp=000000010", known, assigned);
        end
        step(3'd1, 1'b0, 1'b0);
        step(3'b100, 1'b0, 1'b1);
        step(3'b010, 1'b0, 1'b1);
        step(3'b001, 1'b0, 1'b1);
        checks++;
        if (known !== 9'b000_000_010) begin
            failures++; $display("FAIL row1_nocommit got=%b exp=000000010", known);
        end
        step(3'd2, 1'b0, 1'b0);
        step(3'b101, 1'b0, 1'b0);
        checks++;
        if (known !== 9'b111_000_010 || assigned !== 9'b101_000_010) begin
            failures++;
            $display("FAIL row2_single got=%b/%b exp=111000010/101000010", known, assigned);
        end
        step(3'd3, 1'b0, 1'b0);
        step(3'b101, 1'b0, 1'b0);
        checks++;
        if (known !== 9'b111_001_011 || assigned !== 9'b101_000_011) begin
            failures++;
            $display("FAIL col0 got=%b/%b exp=111001011/101000011", known, assigned);
        end
        step(3'd4, 1'b0, 1'b0);
        step(3'b110, 1'b0, 1'b1);
        step(3'b011, 1'b0, 1'b0);
        checks++;
        if (dut.cnt[4] !== 7'd1) begin
            failures++; $display("FAIL cnt4 got=%0d exp=1", dut.cnt[4]);
        end
        checks++;
        if (known !== 9'b111_011_011 || assigned !== 9'b101_010_011) begin
            failures++;
            $display("FAIL col1 got=%b/%b exp=111011011/101010011", known, assigned);
        end
        step(3'd5, 1'b0, 1'b0);
        step(3'b100, 1'b0, 1'b0);
        step(3'b010, 1'b0, 1'b0);
        step(3'b001, 1'b0, 1'b1);
        checks++;
        if (known !== 9'h1FF || assigned !== 9'b101_010_011) begin
            failures++;
            $display("FAIL col2 got=%b/%b exp=111111111/101010011", known, assigned);
        end
        checks++;
        if (solved !== 1'b0) begin
            failures++; $display("FAIL solved_early got=%b exp=0", solved);
        end
        idle();
        checks++;
        if (solved !== 1'b1) begin
            failures++; $display("FAIL solved_rise got=%b exp=1", solved);
        end
        checks++;
        if (put_back_to_FIFO !== 1'b1) begin
            failures++; $display("FAIL pb_hold got=%b exp=1", put_back_to_FIFO);
        end
        idle();
        checks++;
        if (solved !== 1'b1) begin
            failures++; $display("FAIL solved_sticky got=%b exp=1", solved);
        end
    endtask

    task automatic test_back_to_back();
        amnt = {7'd3, 7'd2, 7'd1, 7'd1, 7'd3, 7'd0};
        step(3'd0, 1'b1, 1'b0);
        checks++;
        if (known !== 9'h0 || assigned !== 9'h0 || solved !== 1'b0) begin
            failures++;
            $display("FAIL restart_clear got=%b/%b/%b exp=0", known, assigned, solved);
        end
        step(3'd6, 1'b0, 1'b0);
        step(3'd2, 1'b0, 1'b0);
        step(3'b101, 1'b0, 1'b0);
        checks++;
        if (known !== 9'b111_000_000 || assigned !== 9'b101_000_000) begin
            failures++;
            $display("FAIL zero_count_row2 got=%b/%b exp=111000000/101000000", known, assigned);
        end
        step(3'd3, 1'b0, 1'b0);
        step(3'b111, 1'b0, 1'b0);
        checks++;
        if (known !== 9'b111_001_001 || assigned !== 9'b101_001_001) begin
            failures++;
            $display("FAIL col0_after_oob got=%b/%b exp=111001001/101001001", known, assigned);
        end
    endtask

    task automatic test_small_board();
        num_rows = 4'd2; num_cols = 4'd2;
        amnt = {7'd0, 7'd0, 7'd1, 7'd1, 7'd1, 7'd1};
        step(3'd0, 1'b1, 1'b0);
        step(3'b010, 1'b0, 1'b0);
        checks++;
        if (known !== 9'b000_000_011 || assigned !== 9'b000_000_001) begin
            failures++;
            $display("FAIL small_row0 got=%b/%b exp=000000011/000000001", known, assigned);
        end
        step(3'd1, 1'b0, 1'b0);
        step(3'b001, 1'b0, 1'b0);
        checks++;
        if (known !== 9'b000_011_011 || assigned !== 9'b000_010_001) begin
            failures++;
            $display("FAIL small_row1 got=%b/%b exp=000011011/000010001", known, assigned);
        end
        idle();
        checks++;
        if (solved !== 1'b1) begin
            failures++; $display("FAIL small_solved got=%b exp=1", solved);
        end
    endtask

    task automatic test_reset_mid();
        num_rows = 4'd3; num_cols = 4'd3;
        amnt = {7'd3, 7'd2, 7'd1, 7'd1, 7'd3, 7'd2};
        step(3'd2, 1'b1, 1'b0);
        step(3'b101, 1'b0, 1'b0);
        step(3'd1, 1'b0, 1'b0);
        step(3'b100, 1'b0, 1'b1);
        valid_op = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (put_back_to_FIFO !== 1'b0 || known !== 9'h0 ||
            assigned !== 9'h0 || solved !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got=%b/%b/%b/%b exp=0",
                     put_back_to_FIFO, known, assigned, solved);
        end
        checks++;
        if (dut.cnt !== '0) begin
            failures++; $display("FAIL mid_reset_cnt got=%h exp=0", dut.cnt);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(3'b001, 1'b0, 1'b0);
        step(3'b010, 1'b0, 1'b0);
        checks++;
        if (known !== 9'h0) begin
            failures++; $display("FAIL post_reset_idle got=%b exp=0", known);
        end
        valid_op = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_puzzle();
        test_back_to_back();
        test_small_board();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nonogram_solver.md
# nonogram_solver

Line-at-a-time nonogram constraint propagator for a board of up to SIZE×SIZE cells. It consumes a word stream from the option FIFO: a line-index word, then that line's candidate bit patterns. Each candidate is filtered against the cells already deduced; the block tells the FIFO controller whether to recirculate the candidate, and commits cells on which all surviving candidates agree. It sits between the option FIFO and the board/display logic and flags when every cell is known.

## Interface
- SIZE, 3: maximum board dimension; also the option word width.
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- started  in  1  start pulse; qualified by valid_op; marks the first word of a new puzzle.
- option  in  SIZE  stream word: line index (zero-extended) or candidate pattern.
- num_rows  in  4  active rows R (1..SIZE), stable while solving.
- num_cols  in  4  active columns C (1..SIZE), stable while solving.
- valid_op  in  1  option carries a valid word this cycle.
- old_options_amnt  in  2*SIZE×7  initial candidate count per line; entries 0..R-1 are rows, R..R+C-1 columns; sampled only on start.
- put_back_to_FIFO  out  1  registered: last accepted candidate survives and must be re-queued.
- assigned  out  SIZE×SIZE  registered cell values, [row][col]; meaningful where known=1.
- known  out  SIZE×SIZE  registered cell-deduced flags.
- solved  out  1  registered: all R×C active cells known.

## Operation
- Line index L < R is row L (length C); L ≥ R is column L-R (length R). Cell at position j (0 = left/top) maps to option bit [len-1-j].
- Internal per-line remaining count cnt[L] (7 bits). States: IDLE, EXPECT_INDEX, OPTIONS.
- Word accepted only when valid_op=1; otherwise all state holds.
- started=1 & valid_op=1 (any state): load cnt from old_options_amnt; clear known, assigned, solved; treat the same option word as the first line index.
- Index word: latch L, base = cnt[L], seen = 0, clear accumulators (and1 = all ones, and0 = all ones, survivors = 0). If base = 0 stay in EXPECT_INDEX, else go to OPTIONS. put_back_to_FIFO ← 0.
- Candidate word: conflict if any cell in the line with known=1 has assigned ≠ candidate bit.
  - Conflict: cnt[L] decrements; put_back ← 0.
  - Consistent: survivors++, and1 &= cand, and0 &= ~cand; put_back ← 1, except when base = 1 (sole remaining candidate): put_back ← 0 and the line is fully committed.
- seen increments each candidate; when seen reaches base, commit (if survivors > 0) and return to EXPECT_INDEX. Commit sets known and assigned=1 where and1 bit set, and known and assigned=0 where and0 bit set. Already-known cells are never changed.
- solved computed from known over active cells; once 1, stays 1 until reset or started.
- Out-of-range index (L ≥ R+C) is ignored; remain in EXPECT_INDEX.

## Timing
- Reset: state IDLE; put_back_to_FIFO, known, assigned, solved, all cnt = 0.
- One word per cycle, no back-pressure.
- put_back_to_FIFO valid the cycle after its candidate is sampled; holds until the next accepted word.
- Commit visible on known/assigned the cycle after the line's last candidate is sampled, so the next line (index word next cycle, first candidate the one after) sees it.
- solved rises one cycle after the commit that completes the board.
- IDLE ignores everything except started.

## Test plan
- Reset mid-stream: drive rst=0 during OPTIONS -> all outputs 0 immediately; cnt cleared.
- 3×3 board 110/010/101, counts {2,3,1,1,2,3}: row0 {110,011} -> known[0][1]=1 only; put_back=1 for both.
- Row2 single candidate 101 -> put_back=0; row 2 fully known as 1,0,1.
- Col1 {110,011} after rows: 011 conflicts with [0][1]=1 -> put_back=0, cnt[4]=1; 110 commits column (1,1,0).
- Col2 {100,010,001}: first two conflict with [2][2]=1 (put_back=0), 001 -> put_back=1; after round 1 known = all 1s, solved=1 one cycle later.
- Zero-count line: index word for a line with cnt=0 followed directly by another index word -> second treated as index; no commit, put_back=0.
